// File: rtl/neuron_bank_lif_engine_if.sv
// Bus and spike-stream bundle for neuron_bank_lif_engine.
//   addr/write_en/write_data/read_en  : CPU load/store request (master -> slave)
//   read_data/busywait                : access result and stall (slave -> master)
//   spike_valid/spike_id              : spike FIFO head (slave -> master)
//   spike_ready                       : spike consumer accept (master -> slave)
interface neuron_bank_lif_engine_if;
    logic [31:0] addr;
    logic        write_en;
    logic [31:0] write_data;
    logic        read_en;
    logic [31:0] read_data;
    logic        busywait;
    logic        spike_valid;
    logic [3:0]  spike_id;
    logic        spike_ready;

    modport master (
        output addr, write_en, write_data, read_en, spike_ready,
        input  read_data, busywait, spike_valid, spike_id
    );

    modport slave (
        input  addr, write_en, write_data, read_en, spike_ready,
        output read_data, busywait, spike_valid, spike_id
    );
endinterface

// File: rtl/neuron_bank_lif_engine.sv
// Memory-mapped bank of leaky integrate-and-fire neurons with one shared
// 3-stage update engine (LOAD/COMPUTE/WB) served round-robin, and a spike FIFO.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of neuron_bank_lif_engine_if (load/store port + spike stream)
// Map: neuron n window at n*0x40 (THRESH, V_RESET, LEAK_SH, I_IN, V, SPK_CNT,
// CTRL, STATUS); global window at NUM_NEURONS*0x40 (GCTRL, GSTAT).
module neuron_bank_lif_engine #(
    parameter int NUM_NEURONS      = 4,
    parameter int DATA_W           = 16,
    parameter int SPIKE_FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    neuron_bank_lif_engine_if.slave  bus
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int PTR_W = $clog2(SPIKE_FIFO_DEPTH);

    localparam logic [3:0] R_THRESH = 4'd0, R_VRESET = 4'd1, R_LEAK = 4'd2, R_IIN = 4'd3,
                           R_V = 4'd4, R_SPKCNT = 4'd5, R_CTRL = 4'd6, R_STATUS = 4'd7;
    localparam logic [3:0] G_CTRL = 4'd0, G_STAT = 4'd1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_WB} state_t;

    // ---------------- register file ----------------
    logic [NUM_NEURONS-1:0][DATA_W-1:0] thresh, v_reset, i_in, v;
    logic [NUM_NEURONS-1:0][3:0]        leak_sh;
    logic [NUM_NEURONS-1:0][15:0]       spk_cnt;
    logic [NUM_NEURONS-1:0]             pending, spiked_last;

    // ---------------- engine state ----------------
    state_t                    state;
    logic [IDX_W-1:0]          cur, rr_ptr, nxt_ptr;
    logic                      restart_q;
    logic signed [DATA_W-1:0]  v_l, i_l, th_l, vr_l, vn_q;
    logic [3:0]                sh_l;

    // ---------------- spike FIFO ----------------
    logic [SPIKE_FIFO_DEPTH-1:0][IDX_W-1:0] fifo_mem;
    logic [PTR_W:0]            wr_ptr, rd_ptr;
    logic                      fifo_empty, fifo_full, fifo_ovf, push, pop;

    // ---------------- bus decode ----------------
    logic [25:0]       win;
    logic [3:0]        reg_idx;
    logic [IDX_W-1:0]  n_idx;
    logic              is_neuron, is_global;
    logic              req, ack_q, hazard, fire, wr_fire, rd_fire;
    logic [31:0]       rdata, read_data_q;
    logic [DATA_W-1:0] wd;
    logic              unused_bits;

    assign win       = bus.addr[31:6];
    assign reg_idx   = bus.addr[5:2];
    assign n_idx     = bus.addr[6 +: IDX_W];
    assign is_neuron = win < 26'(NUM_NEURONS);
    assign is_global = win == 26'(NUM_NEURONS);
    assign wd        = bus.write_data[DATA_W-1:0];
    assign unused_bits = ^{bus.addr[1:0], bus.write_data};

    // Writes to the neuron the engine is working on stall until it is idle again.
    // CTRL is exempt: a start there is remembered via restart_q instead.
    assign hazard  = bus.write_en && is_neuron && (state != S_IDLE) &&
                     (n_idx == cur) && (reg_idx != R_CTRL);
    assign req     = bus.write_en | bus.read_en;
    // ack_q marks the cycle after completion, so busywait drops for exactly that cycle
    assign bus.busywait = req & ~ack_q;
    assign fire    = req & ~ack_q & ~hazard;
    assign wr_fire = fire & bus.write_en;
    assign rd_fire = fire & ~bus.write_en & bus.read_en;
    assign bus.read_data = read_data_q;

    // ---------------- pending bookkeeping ----------------
    logic [NUM_NEURONS-1:0] set_vec, clr_vec, pending_n;

    always_comb begin
        set_vec = '0;
        if (wr_fire && bus.write_data[0]) begin
            if (is_neuron && reg_idx == R_CTRL) set_vec[n_idx] = 1'b1;
            if (is_global && reg_idx == G_CTRL) set_vec = '1;
        end
    end

    always_comb begin
        clr_vec = '0;
        if (state == S_WB && !restart_q) clr_vec[cur] = 1'b1;
    end

    assign pending_n = (pending & ~clr_vec) | set_vec;
    assign nxt_ptr   = (cur == IDX_W'(NUM_NEURONS - 1)) ? '0 : cur + 1'b1;

    // Round-robin pick. From WB we chain straight into the next LOAD so a
    // busy bank costs 3 cycles per neuron, using the post-WB pending view.
    logic [NUM_NEURONS-1:0] pick_vec;
    logic [IDX_W-1:0]       pick_start, pick_idx;
    logic                   pick_found;
    int                     pj;

    always_comb begin
        pick_vec   = (state == S_WB) ? pending_n : pending;
        pick_start = (state == S_WB) ? nxt_ptr : rr_ptr;
        pick_found = 1'b0;
        pick_idx   = '0;
        pj         = 0;
        // descending scan so the lowest offset from pick_start wins
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            pj = (int'(pick_start) + i) % NUM_NEURONS;
            if (pick_vec[pj]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(pj);
            end
        end
    end

    // ---------------- datapath ----------------
    logic signed [DATA_W-1:0] shifted, sat_v;
    logic [DATA_W+1:0]        sum;
    logic                     spike_now;

    always_comb begin
        shifted = v_l >>> sh_l;
        sum = {{2{v_l[DATA_W-1]}}, v_l} - {{2{shifted[DATA_W-1]}}, shifted}
            + {{2{i_l[DATA_W-1]}}, i_l};
        // the top three bits agree only when the result fits in DATA_W
        if (sum[DATA_W+1:DATA_W-1] == 3'b000 || sum[DATA_W+1:DATA_W-1] == 3'b111)
            sat_v = sum[DATA_W-1:0];
        else if (sum[DATA_W+1])
            sat_v = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat_v = {1'b0, {(DATA_W-1){1'b1}}};
    end

    assign spike_now = vn_q >= th_l;

    // ---------------- engine FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cur       <= '0;
            rr_ptr    <= '0;
            restart_q <= 1'b0;
            v_l       <= '0;
            i_l       <= '0;
            th_l      <= '0;
            vr_l      <= '0;
            sh_l      <= '0;
            vn_q      <= '0;
        end else begin
            case (state)
                S_IDLE: if (pick_found) begin
                    cur   <= pick_idx;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    v_l   <= v[cur];
                    i_l   <= i_in[cur];
                    th_l  <= thresh[cur];
                    vr_l  <= v_reset[cur];
                    sh_l  <= leak_sh[cur];
                    if (set_vec[cur]) restart_q <= 1'b1;
                    state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    vn_q  <= sat_v;
                    if (set_vec[cur]) restart_q <= 1'b1;
                    state <= S_WB;
                end
                default: begin
                    rr_ptr    <= nxt_ptr;
                    restart_q <= 1'b0;
                    if (pick_found) begin
                        cur   <= pick_idx;
                        state <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- register file writes ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thresh      <= '0;
            v_reset     <= '0;
            i_in        <= '0;
            v           <= '0;
            leak_sh     <= '0;
            spk_cnt     <= '0;
            pending     <= '0;
            spiked_last <= '0;
        end else begin
            pending <= pending_n;
            if (wr_fire && is_neuron) begin
                case (reg_idx)
                    R_THRESH: thresh[n_idx]  <= wd;
                    R_VRESET: v_reset[n_idx] <= wd;
                    R_LEAK:   leak_sh[n_idx] <= bus.write_data[3:0];
                    R_IIN:    i_in[n_idx]    <= wd;
                    R_V:      v[n_idx]       <= wd;
                    default: ;
                endcase
            end
            // bus never targets cur here: hazard holds those writes off
            if (state == S_WB) begin
                if (spike_now) begin
                    v[cur]           <= vr_l;
                    spk_cnt[cur]     <= spk_cnt[cur] + 16'd1;
                    spiked_last[cur] <= 1'b1;
                end else begin
                    v[cur]           <= vn_q;
                    spiked_last[cur] <= 1'b0;
                end
            end
        end
    end

    // ---------------- read path ----------------
    logic engine_busy;
    assign engine_busy = (state != S_IDLE) || (|pending);

    always_comb begin
        rdata = '0;
        if (is_neuron) begin
            case (reg_idx)
                R_THRESH: rdata = 32'($signed(thresh[n_idx]));
                R_VRESET: rdata = 32'($signed(v_reset[n_idx]));
                R_LEAK:   rdata = {28'd0, leak_sh[n_idx]};
                R_IIN:    rdata = 32'($signed(i_in[n_idx]));
                R_V:      rdata = 32'($signed(v[n_idx]));
                R_SPKCNT: rdata = {16'd0, spk_cnt[n_idx]};
                R_STATUS: rdata = {30'd0, spiked_last[n_idx], pending[n_idx]};
                default:  rdata = '0;
            endcase
        end else if (is_global && reg_idx == G_STAT) begin
            rdata = {30'd0, fifo_ovf, engine_busy};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            ack_q <= fire;
            if (rd_fire) read_data_q <= rdata;
        end
    end

    // ---------------- spike FIFO ----------------
    assign fifo_empty      = (wr_ptr == rd_ptr);
    assign fifo_full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                             (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push            = (state == S_WB) && spike_now;
    assign pop             = ~fifo_empty & bus.spike_ready;
    assign bus.spike_valid = ~fifo_empty;
    assign bus.spike_id    = 4'(fifo_mem[rd_ptr[PTR_W-1:0]]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            // a pop in the same cycle frees the slot, so full+pop still accepts
            if (push && (!fifo_full || pop)) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= cur;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && fifo_full && !pop)
                fifo_ovf <= 1'b1;
            else if (wr_fire && is_global && reg_idx == G_STAT && bus.write_data[1])
                fifo_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_neuron_bank_lif_engine.sv
// Directed bench for neuron_bank_lif_engine: bus handshake, single-neuron
// integrate/fire, start-all ordering and timing, FIFO overflow, saturation,
// write hazard stall and asynchronous reset mid-update.
module tb_neuron_bank_lif_engine;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    neuron_bank_lif_engine_if bus ();

    neuron_bank_lif_engine #(
        .NUM_NEURONS(4), .DATA_W(16), .SPIKE_FIFO_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // one bus access; stalls = cycles busywait was seen high
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic rd_too, output int stalls);
        @(negedge clk);
        bus.addr = a; bus.write_data = d; bus.write_en = 1'b1; bus.read_en = rd_too;
        stalls = 0;
        #1;
        while (bus.busywait === 1'b1 && stalls < 64) begin
            stalls++;
            @(negedge clk); #1;
        end
        bus.write_en = 1'b0; bus.read_en = 1'b0;
        if (stalls >= 64) begin
            n_checks++; n_fail++;
            $display("FAIL bus_write_timeout addr=%h", a);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int stalls);
        @(negedge clk);
        bus.addr = a; bus.write_en = 1'b0; bus.read_en = 1'b1;
        stalls = 0;
        #1;
        while (bus.busywait === 1'b1 && stalls < 64) begin
            stalls++;
            @(negedge clk); #1;
        end
        d = bus.read_data;
        bus.read_en = 1'b0;
        if (stalls >= 64) begin
            n_checks++; n_fail++;
            $display("FAIL bus_read_timeout addr=%h", a);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int s;
        bus_write(a, d, 1'b0, s);
    endtask

    task automatic test_reset;
        logic [31:0] d; int st;
        rst = 1'b0;
        bus.addr = '0; bus.write_en = 1'b0; bus.write_data = '0;
        bus.read_en = 1'b0; bus.spike_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus.busywait !== 1'b0) begin n_fail++; $display("FAIL rst_busywait got %b want 0", bus.busywait); end
        n_checks++; if (bus.read_data !== 32'h0) begin n_fail++; $display("FAIL rst_read_data got %h want 0", bus.read_data); end
        n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL rst_spike_valid got %b want 0", bus.spike_valid); end
        @(negedge clk); rst = 1'b1;
        bus_read(32'h0000_0000, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_thresh0 got %h want 0", d); end
        bus_read(32'h0000_0104, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_gstat got %h want 0", d); end
    endtask

    task automatic test_basic_access;
        logic [31:0] d; int st;
        bus_write(32'h44, 32'h100, 1'b0, st);
        n_checks++; if (st !== 1) begin n_fail++; $display("FAIL wr_latency got %0d want 1", st); end
        bus_read(32'h44, d, st);
        n_checks++; if (st !== 1) begin n_fail++; $display("FAIL rd_latency got %0d want 1", st); end
        n_checks++; if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL rd_0x44 got %h want 00000100", d); end
        // write and read together: write wins, read_data keeps last read value
        bus_write(32'h40, 32'h55, 1'b1, st);
        n_checks++; if (bus.read_data !== 32'h0000_0100) begin n_fail++; $display("FAIL write_wins_hold got %h want 00000100", bus.read_data); end
        bus_read(32'h40, d, st);
        n_checks++; if (d !== 32'h55) begin n_fail++; $display("FAIL write_wins_data got %h want 55", d); end
        bus_read(32'h60, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd got %h want 0", d); end
        wr(32'h1000, 32'hAB);
        bus_read(32'h1000, d, st);
        n_checks++; if (d !== 32'h0 || st !== 1) begin n_fail++; $display("FAIL oor_rd got %h/%0d want 0/1", d, st); end
        bus_read(32'h58, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_rd got %h want 0", d); end
    endtask

    task automatic test_single_neuron;
        logic [31:0] d; int st;
        bus.spike_ready = 1'b0;
        wr(32'h00, 32'd100); wr(32'h04, 32'hFFFD); wr(32'h08, 32'd15);
        wr(32'h0C, 32'd60);  wr(32'h10, 32'd0);
        wr(32'h18, 32'h1);
        repeat (6) @(negedge clk);
        bus_read(32'h10, d, st);
        n_checks++; if (d !== 32'd60) begin n_fail++; $display("FAIL n0_v_first got %h want 3c", d); end
        bus_read(32'h1C, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL n0_status_first got %h want 0", d); end
        n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL n0_no_spike got %b want 0", bus.spike_valid); end
        wr(32'h18, 32'h1);
        repeat (6) @(negedge clk);
        bus_read(32'h10, d, st);
        n_checks++; if (d !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL n0_v_reset got %h want fffffffd", d); end
        bus_read(32'h14, d, st);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL n0_spk_cnt got %h want 1", d); end
        bus_read(32'h1C, d, st);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL n0_status_spiked got %h want 2", d); end
        #1;
        n_checks++; if (bus.spike_valid !== 1'b1 || bus.spike_id !== 4'd0) begin n_fail++; $display("FAIL n0_spike_head got %b/%0d want 1/0", bus.spike_valid, bus.spike_id); end
        @(negedge clk); bus.spike_ready = 1'b1;
        @(negedge clk); bus.spike_ready = 1'b0; #1;
        n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL n0_popped got %b want 0", bus.spike_valid); end
    endtask

    task automatic test_start_all;
        logic [31:0] d; int st; int cnt;
        int got_id[4]; int got_at[4];
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wr(32'(n * 64) + 32'h00, 32'h0);
            wr(32'(n * 64) + 32'h04, 32'h0);
            wr(32'(n * 64) + 32'h08, 32'h0);
            wr(32'(n * 64) + 32'h0C, 32'h1);
            wr(32'(n * 64) + 32'h10, 32'h0);
        end
        bus.spike_ready = 1'b1;
        bus_write(32'h100, 32'h1, 1'b0, st);
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); #1;
            if (bus.spike_valid === 1'b1 && cnt < 4) begin
                got_id[cnt] = int'(bus.spike_id);
                got_at[cnt] = i;
                cnt++;
            end
        end
        n_checks++; if (cnt !== 4) begin n_fail++; $display("FAIL all_spike_count got %0d want 4", cnt); end
        for (int k = 0; k < cnt; k++) begin
            n_checks++; if (got_id[k] !== k) begin n_fail++; $display("FAIL all_spike_order[%0d] got %0d want %0d", k, got_id[k], k); end
        end
        if (cnt == 4) begin
            // LOAD of neuron 0 one cycle after the start write; 3 cycles per neuron
            n_checks++; if (got_at[0] !== 4 || got_at[3] !== 13) begin n_fail++; $display("FAIL all_spike_timing got %0d..%0d want 4..13", got_at[0], got_at[3]); end
        end
        bus_read(32'h104, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL all_gstat_idle got %h want 0", d); end
        bus_read(32'h94, d, st);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL all_n2_cnt got %h want 1", d); end
    endtask

    task automatic test_fifo_overflow;
        logic [31:0] d; int st;
        bus.spike_ready = 1'b0;
        wr(32'h100, 32'h1);
        repeat (15) @(negedge clk);
        wr(32'h18, 32'h1);
        repeat (8) @(negedge clk);
        bus_read(32'h104, d, st);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL ovf_gstat got %h want 2", d); end
        bus_read(32'h14, d, st);
        n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL ovf_n0_cnt got %h want 3", d); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            n_checks++; if (bus.spike_valid !== 1'b1 || bus.spike_id !== 4'(k)) begin n_fail++; $display("FAIL ovf_fifo[%0d] got %b/%0d want 1/%0d", k, bus.spike_valid, bus.spike_id, k); end
            bus.spike_ready = 1'b1;
            @(negedge clk); bus.spike_ready = 1'b0;
        end
        #1;
        n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_fifo_empty got %b want 0", bus.spike_valid); end
        wr(32'h104, 32'h2);
        bus_read(32'h104, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ovf_clear got %h want 0", d); end
    endtask

    task automatic test_saturation;
        logic [31:0] d; int st;
        bus.spike_ready = 1'b1;
        // a wrapped sum would be negative and not reach THRESH=0x7FFF
        wr(32'hC0, 32'h7FFF); wr(32'hC4, 32'h11); wr(32'hC8, 32'd15);
        wr(32'hCC, 32'h0100); wr(32'hD0, 32'h7FF0);
        wr(32'hD8, 32'h1);
        repeat (6) @(negedge clk);
        bus_read(32'hD0, d, st);
        n_checks++; if (d !== 32'h11) begin n_fail++; $display("FAIL sat_pos_v got %h want 11", d); end
        bus_read(32'hD4, d, st);
        n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL sat_pos_cnt got %h want 3", d); end
        wr(32'hD0, 32'h8010); wr(32'hCC, 32'hFF00);
        wr(32'hD8, 32'h1);
        repeat (6) @(negedge clk);
        bus_read(32'hD0, d, st);
        n_checks++; if (d !== 32'hFFFF_8000) begin n_fail++; $display("FAIL sat_neg_v got %h want ffff8000", d); end
        bus_read(32'hDC, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sat_neg_status got %h want 0", d); end
    endtask

    task automatic test_hazard_and_reset;
        logic [31:0] d; int st;
        wr(32'h80, 32'h7FFF); wr(32'h88, 32'd15); wr(32'h8C, 32'd5); wr(32'h90, 32'd10);
        wr(32'h98, 32'h1);
        @(negedge clk);
        // issued while N2 is in COMPUTE: stalls through WB and the IDLE cycle
        bus_write(32'h90, 32'h222, 1'b0, st);
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL hazard_stall got %0d want 3", st); end
        bus_read(32'h90, d, st);
        n_checks++; if (d !== 32'h222) begin n_fail++; $display("FAIL hazard_v got %h want 222", d); end
        bus_read(32'h9C, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL hazard_status got %h want 0", d); end
        wr(32'h98, 32'h1);
        bus_read(32'h104, d, st);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL midupd_busy got %h want 1", d); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.read_data !== 32'h0 || bus.busywait !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs got %h/%b want 0/0", bus.read_data, bus.busywait); end
        @(negedge clk); rst = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(32'h9C, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_status got %h want 0", d); end
        bus_read(32'h90, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_v got %h want 0", d); end
        bus_read(32'h104, d, st);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_gstat got %h want 0", d); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_access();
        test_single_neuron();
        test_start_all();
        test_fifo_overflow();
        test_saturation();
        test_hazard_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
